// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK transmit path: state encoding, symbol
// constants and the packed I/Q sample type.
package qpsk_pkg;

  localparam int SYMS_PER_WORD = 16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_DATA     = 2'd2;

  // Bit value that maps to +AMP on either axis; the opposite value maps to -AMP.
  localparam logic MAP_POS_BIT = 1'b0;

  localparam logic [1:0] PRE_SYM_A = 2'b00;
  localparam logic [1:0] PRE_SYM_B = 2'b11;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } iq_t;

  // Symbol idx of a packed word, MSB-first: idx 0 is word[31:30].
  function automatic logic [1:0] word_dibit(input logic [31:0] word, input logic [3:0] idx);
    logic [4:0] lsb;
    lsb = 5'd30 - {idx, 1'b0};
    return word[lsb +: 2];
  endfunction

endpackage

// File: rtl/qpsk_symbol_map.sv
// Gray dibit to I/Q level mapper; dibit MSB drives I, LSB drives Q.
module qpsk_symbol_map
  import qpsk_pkg::*;
(
  input  logic [1:0]         dibit_i,
  input  logic signed [15:0] amp_i,
  output iq_t                iq_o
);

  assign iq_o.i = (dibit_i[1] == MAP_POS_BIT) ? amp_i : -amp_i;
  assign iq_o.q = (dibit_i[0] == MAP_POS_BIT) ? amp_i : -amp_i;

endmodule

// File: rtl/qpsk_mod.sv
// QPSK modulator: packed dibit words in, optional alternating preamble,
// rectangular-pulse {I,Q} samples out at SPS samples per symbol.
module qpsk_mod
  import qpsk_pkg::*;
#(
  parameter int                 SPS   = 16,
  parameter logic signed [15:0] AMP   = 16'sd11585,
  parameter int                 PRE_W = 8
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic [PRE_W-1:0] preamble_len,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready
);

  localparam int             CW       = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0]  SMP_LAST = CW'(SPS - 1);
  localparam logic [3:0]     SYM_LAST = 4'(SYMS_PER_WORD - 1);

  logic [1:0]       state_q,    state_d;
  logic [31:0]      word_q,     word_d;
  logic             last_q,     last_d;
  logic [31:0]      buf_q,      buf_d;
  logic             buf_last_q, buf_last_d;
  logic             buf_vld_q,  buf_vld_d;
  logic [PRE_W-1:0] pre_cnt_q,  pre_cnt_d;
  logic             pre_ph_q,   pre_ph_d;
  logic [3:0]       sym_q,      sym_d;
  logic [CW-1:0]    smp_q,      smp_d;
  logic             rdy_en_q;
  logic             tvalid_q,   tvalid_d;
  logic             tlast_q,    tlast_d;
  iq_t              tdata_q,    tdata_d;

  logic             out_hs, smp_end, word_done, s_accept;
  logic [1:0]       dibit_nxt;
  iq_t              iq_nxt;

  // No prefetch past a packet end, so preamble_len is always sampled in IDLE.
  always_comb begin
    case (state_q)
      ST_IDLE: s_axis_tready = rdy_en_q;
      ST_DATA: s_axis_tready = !buf_vld_q && !last_q;
      default: s_axis_tready = 1'b0;
    endcase
  end

  assign s_accept  = s_axis_tvalid & s_axis_tready;
  assign out_hs    = tvalid_q & m_axis_tready;
  assign smp_end   = (smp_q == SMP_LAST);
  assign word_done = out_hs & smp_end & (sym_q == SYM_LAST);

  always_comb begin
    // NOTE: every next-state signal takes its held value first so no path infers a latch.
    state_d    = state_q;
    word_d     = word_q;
    last_d     = last_q;
    buf_d      = buf_q;
    buf_last_d = buf_last_q;
    buf_vld_d  = buf_vld_q;
    pre_cnt_d  = pre_cnt_q;
    pre_ph_d   = pre_ph_q;
    sym_d      = sym_q;
    smp_d      = smp_q;
    tvalid_d   = tvalid_q;

    case (state_q)
      ST_IDLE: begin
        if (s_accept) begin
          word_d    = s_axis_tdata;
          last_d    = s_axis_tlast;
          pre_cnt_d = preamble_len;
          pre_ph_d  = 1'b0;
          sym_d     = '0;
          smp_d     = '0;
          tvalid_d  = 1'b1;
          state_d   = (preamble_len != '0) ? ST_PREAMBLE : ST_DATA;
        end
      end

      ST_PREAMBLE: begin
        if (out_hs) begin
          if (smp_end) begin
            smp_d = '0;
            if (pre_cnt_q == PRE_W'(1)) begin
              state_d = ST_DATA;
              sym_d   = '0;
            end else begin
              pre_cnt_d = pre_cnt_q - PRE_W'(1);
              pre_ph_d  = !pre_ph_q;
            end
          end else begin
            smp_d = smp_q + CW'(1);
          end
        end
      end

      ST_DATA: begin
        if (!tvalid_q) begin
          // Underrun: restart output as soon as a word shows up.
          if (s_accept) begin
            word_d   = s_axis_tdata;
            last_d   = s_axis_tlast;
            sym_d    = '0;
            smp_d    = '0;
            tvalid_d = 1'b1;
          end
        end else if (out_hs) begin
          if (smp_end) begin
            smp_d = '0;
            sym_d = sym_q + 4'd1;
            if (sym_q == SYM_LAST) begin
              if (last_q) begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
              end else if (buf_vld_q) begin
                word_d    = buf_q;
                last_d    = buf_last_q;
                buf_vld_d = 1'b0;
              end else if (s_accept) begin
                word_d = s_axis_tdata;
                last_d = s_axis_tlast;
              end else begin
                tvalid_d = 1'b0;
              end
            end
          end else begin
            smp_d = smp_q + CW'(1);
          end
        end

        if (s_accept && tvalid_q && !word_done) begin
          buf_d      = s_axis_tdata;
          buf_last_d = s_axis_tlast;
          buf_vld_d  = 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
      end
    endcase

    dibit_nxt = (state_d == ST_PREAMBLE) ? (pre_ph_d ? PRE_SYM_B : PRE_SYM_A)
                                         : word_dibit(word_d, sym_d);
    tlast_d   = tvalid_d && (state_d == ST_DATA) && last_d &&
                (sym_d == SYM_LAST) && (smp_d == SMP_LAST);
    tdata_d   = tvalid_d ? iq_nxt : tdata_q;
  end

  qpsk_symbol_map u_map (
    .dibit_i (dibit_nxt),
    .amp_i   (AMP),
    .iq_o    (iq_nxt)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ce_clk or negedge ce_rst) begin
    if (!ce_rst) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      last_q     <= 1'b0;
      buf_q      <= '0;
      buf_last_q <= 1'b0;
      buf_vld_q  <= 1'b0;
      pre_cnt_q  <= '0;
      pre_ph_q   <= 1'b0;
      sym_q      <= '0;
      smp_q      <= '0;
      rdy_en_q   <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      last_q     <= last_d;
      buf_q      <= buf_d;
      buf_last_q <= buf_last_d;
      buf_vld_q  <= buf_vld_d;
      pre_cnt_q  <= pre_cnt_d;
      pre_ph_q   <= pre_ph_d;
      sym_q      <= sym_d;
      smp_q      <= smp_d;
      rdy_en_q   <= 1'b1;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tdata  = tdata_q;

endmodule
